// File: rtl/interboard_mux_output.sv
// Round-robin mux of NUM_CH show-ahead FIFOs onto one interboard link,
// gated by per-channel receiver credits, with an idle keepalive pulse.
module interboard_mux_output #(
    parameter int DATA_W       = 11,
    parameter int NUM_CH       = 4,
    parameter int CREDITS      = 8,
    parameter int IDLE_TIMEOUT = 64,
    localparam int CH_W        = $clog2(NUM_CH),
    localparam int CR_W        = $clog2(CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] fifo_data,
    input  logic [NUM_CH-1:0]        fifo_empty,
    output logic [NUM_CH-1:0]        fifo_rdreq,
    input  logic                     credit_return,
    input  logic [CH_W-1:0]          credit_ch,
    output logic                     link_valid,
    output logic [CH_W-1:0]          link_ch,
    output logic [DATA_W-1:0]        link_data,
    output logic                     link_parity,
    output logic                     link_sync,
    output logic [NUM_CH*CR_W-1:0]   credit_count,
    output logic                     credit_err
);
    localparam int ID_W = $clog2(IDLE_TIMEOUT);
    localparam logic [CH_W:0]   CH_LIM = (CH_W + 1)'(NUM_CH);
    localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDITS);
    localparam logic [ID_W-1:0] ID_MAX = ID_W'(IDLE_TIMEOUT - 1);
    localparam logic [CH_W-1:0] PTR_RST = CH_W'(NUM_CH - 1);

    logic [CR_W-1:0]   cred_q [NUM_CH];
    logic [CR_W-1:0]   cred_d [NUM_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   idle_q, idle_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              sync_q, sync_d;

    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] inc_v, dec_v;
    logic              grant;
    logic [CH_W-1:0]   gnt;
    logic [CH_W-1:0]   cand;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = enable && !fifo_empty[i] && (cred_q[i] != '0);
        end
    end

    // Search starts one past the last grant, wrapping modulo NUM_CH.
    always_comb begin
        grant = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (!grant && elig[cand]) begin
                grant = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        fifo_rdreq = '0;
        if (grant) begin
            fifo_rdreq[gnt] = 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (credit_return && ({1'b0, credit_ch} >= CH_LIM)) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            inc_v[i] = credit_return &&
                       ({1'b0, credit_ch} == (CH_W + 1)'(i));
            dec_v[i] = grant && (gnt == CH_W'(i));
            cred_d[i] = cred_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                if (cred_q[i] == CR_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cred_d[i] = cred_q[i] + 1'b1;
                end
            end else if (dec_v[i] && !inc_v[i]) begin
                cred_d[i] = cred_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = grant;
        ch_d    = ch_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (grant) begin
            ch_d   = gnt;
            data_d = fifo_data[int'(gnt)*DATA_W +: DATA_W];
            ptr_d  = gnt;
        end
        par_d = ^{ch_d, data_d};
    end

    // Keepalive only fires on a no-grant cycle, so it never overlaps a word.
    always_comb begin
        sync_d = 1'b0;
        idle_d = idle_q + 1'b1;
        if (grant) begin
            idle_d = '0;
        end else if (idle_q == ID_MAX) begin
            idle_d = '0;
            sync_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cred_q[i] <= CR_MAX;
            end
            ptr_q   <= PTR_RST;
            idle_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cred_q[i] <= cred_d[i];
            end
            ptr_q   <= ptr_d;
            idle_q  <= idle_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            par_q   <= par_d;
            sync_q  <= sync_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cc
        assign credit_count[g*CR_W +: CR_W] = cred_q[g];
    end

    assign link_valid  = valid_q;
    assign link_ch     = ch_q;
    assign link_data   = data_q;
    assign link_parity = par_q;
    assign link_sync   = sync_q;
    assign credit_err  = err_q;

endmodule

// File: tb/tb_interboard_mux_output.sv
// Directed self-checking bench for interboard_mux_output.
// FIFOs are modelled as word counters with a per-channel data pattern.
module tb_interboard_mux_output;
    localparam int DATA_W = 11;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CR_W   = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [NUM_CH*DATA_W-1:0] fifo_data;
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH-1:0]        fifo_rdreq;
    logic                     credit_return;
    logic [CH_W-1:0]          credit_ch;
    logic                     link_valid;
    logic [CH_W-1:0]          link_ch;
    logic [DATA_W-1:0]        link_data;
    logic                     link_parity;
    logic                     link_sync;
    logic [NUM_CH*CR_W-1:0]   credit_count;
    logic                     credit_err;

    int cnt [NUM_CH];
    int idx [NUM_CH];
    int checks = 0;
    int failures = 0;
    int syncs;
    logic [NUM_CH-1:0] popped;

    interboard_mux_output dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .credit_return(credit_return),
        .credit_ch(credit_ch), .link_valid(link_valid),
        .link_ch(link_ch), .link_data(link_data),
        .link_parity(link_parity), .link_sync(link_sync),
        .credit_count(credit_count), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] dat(int c, int n);
        return DATA_W'(c * 300 + n * 7 + 5);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fifo_empty[i] = (cnt[i] == 0);
            fifo_data[i*DATA_W +: DATA_W] = dat(i, idx[i]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input int c, input int n);
        logic [DATA_W-1:0] d;
        logic [CH_W-1:0]   cc;
        d  = dat(c, n);
        cc = CH_W'(c);
        chk({tag, "_valid"}, 32'(link_valid), 32'd1);
        chk({tag, "_ch"}, 32'(link_ch), 32'(c));
        chk({tag, "_data"}, 32'(link_data), 32'(d));
        chk({tag, "_par"}, 32'(link_parity), 32'(^{cc, d}));
    endtask

    function automatic int cc_of(int i);
        return int'(credit_count[i*CR_W +: CR_W]);
    endfunction

    task automatic tick();
        #1;
        popped = fifo_rdreq;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (popped[i]) begin
                cnt[i]--;
                idx[i]++;
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] = 0;
            idx[i] = 0;
        end
        credit_return = 1'b0;
        credit_ch = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        enable = 1'b0;
        credit_return = 1'b0;
        credit_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] = 0;
            idx[i] = 0;
        end
        // T1 reset values
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(link_valid), 0);
        chk("rst_ch", 32'(link_ch), 0);
        chk("rst_data", 32'(link_data), 0);
        chk("rst_par", 32'(link_parity), 0);
        chk("rst_sync", 32'(link_sync), 0);
        chk("rst_err", 32'(credit_err), 0);
        chk("rst_rdreq", 32'(fifo_rdreq), 0);
        for (int i = 0; i < NUM_CH; i++) chk("rst_cred", cc_of(i), 8);
        reset = 1'b1;

        // T5 idle keepalive: first pulse after the 64th edge
        enable = 1'b1;
        syncs = 0;
        for (int k = 0; k < 63; k++) begin
            tick();
            syncs += int'(link_sync);
        end
        chk("idle_early_sync", syncs, 0);
        tick();
        chk("idle_sync", 32'(link_sync), 1);
        chk("idle_sync_novalid", 32'(link_valid), 0);
        tick();
        chk("idle_sync_1cyc", 32'(link_sync), 0);

        // T5 enable=0 blocks grants
        enable = 1'b0;
        cnt[1] = 3;
        #1;
        chk("dis_rdreq", 32'(fifo_rdreq), 0);
        tick();
        chk("dis_valid0", 32'(link_valid), 0);
        tick();
        chk("dis_valid1", 32'(link_valid), 0);
        enable = 1'b1;
        #1;
        chk("en_rdreq", 32'(fifo_rdreq), 32'h2);
        tick();
        chk_word("en_word", 1, 0);

        // T2 credit exhaustion on ch0
        do_reset();
        cnt[0] = 10;
        #1;
        chk("t2_rdreq", 32'(fifo_rdreq), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_word("t2_word", 0, k);
        end
        chk("t2_cred0", cc_of(0), 0);
        chk("t2_stall_rdreq", 32'(fifo_rdreq), 0);
        tick();
        chk("t2_stall_valid", 32'(link_valid), 0);
        chk("t2_hold_ch", 32'(link_ch), 0);
        chk("t2_hold_data", 32'(link_data), 32'(dat(0, 7)));
        credit_return = 1'b1;
        credit_ch = 2'd0;
        tick();
        credit_return = 1'b0;
        chk("t2_ret_valid", 32'(link_valid), 0);
        chk("t2_ret_cred", cc_of(0), 1);
        #1;
        chk("t2_ret_rdreq", 32'(fifo_rdreq), 32'h1);
        tick();
        chk_word("t2_word9", 0, 8);
        chk("t2_cred_end", cc_of(0), 0);

        // T3 round robin with returns every cycle
        do_reset();
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 20;
        for (int k = 0; k < 12; k++) begin
            credit_return = (k > 0);
            credit_ch = CH_W'((k + 3) % 4);
            tick();
            chk_word("t3_word", k % 4, k / 4);
        end
        enable = 1'b0;
        credit_return = 1'b1;
        credit_ch = 2'd3;
        tick();
        credit_return = 1'b0;
        chk("t3_dis_valid", 32'(link_valid), 0);
        for (int i = 0; i < NUM_CH; i++) chk("t3_cred", cc_of(i), 8);
        chk("t3_err", 32'(credit_err), 0);
        enable = 1'b1;

        // T4 grant/return collision and overflow
        do_reset();
        cnt[2] = 7;
        for (int k = 0; k < 7; k++) tick();
        chk("t4_cred_low", cc_of(2), 1);
        chk_word("t4_last", 2, 6);
        cnt[2] = 1;
        credit_return = 1'b1;
        credit_ch = 2'd2;
        tick();
        chk_word("t4_coll", 2, 7);
        chk("t4_coll_cred", cc_of(2), 1);
        chk("t4_coll_err", 32'(credit_err), 0);
        for (int k = 0; k < 7; k++) tick();
        chk("t4_full_cred", cc_of(2), 8);
        chk("t4_full_err", 32'(credit_err), 0);
        tick();
        credit_return = 1'b0;
        chk("t4_ovf_cred", cc_of(2), 8);
        chk("t4_ovf_err", 32'(credit_err), 1);
        tick();
        chk("t4_err_sticky", 32'(credit_err), 1);

        // T6 mid-operation reset
        do_reset();
        chk("t6_err_clr", 32'(credit_err), 0);
        cnt[0] = 20;
        cnt[1] = 5;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_word("t6_pre", k % 2, k / 2);
        end
        chk("t6_pre_valid", 32'(link_valid), 1);
        reset = 1'b0;
        #1;
        chk("t6_async_valid", 32'(link_valid), 0);
        chk("t6_async_data", 32'(link_data), 0);
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < NUM_CH; i++) chk("t6_cred", cc_of(i), 8);
        chk("t6_rdreq", 32'(fifo_rdreq), 32'h1);
        tick();
        chk_word("t6_first", 0, 2);
        chk("t6_cred0", cc_of(0), 7);
        tick();
        chk_word("t6_second", 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
